rx_datapath: RTL and testbench

UART receive datapath: the counterpart of the transmit datapath, decoding the same frame it produces. The frame is start bit, 8 data bits LSB first, always one parity bit, then 1 or 2 stop bits. The block synchronises the serial input, detects and validates the start bit, and samples each bit at mid-period using a programmable bit period. It presents the received byte with a one-cycle valid pulse and parity/framing error flags to the UART register/LSU side of the pipeline.

---
 rtl/rx_datapath.sv | 173 +++++++++++++++++
 tb/tb_rx_datapath.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_datapath.sv
// UART receive datapath: 2-flop synchroniser, start-bit validation and mid-bit
// sampling of an 8N/P frame (start, 8 data LSB first, parity, 1 or 2 stops).
module rx_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_in,
  input  logic [11:0] baud_divisor,
  input  logic        parity_sel,
  input  logic        two_stop_bits,
  input  logic        rx_sel,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        parity_err,
  output logic        frame_err,
  output logic        rx_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic [11:0] ctr_q, ctr_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_bit_q, par_bit_d;
  logic        stop_err_q, stop_err_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        parity_err_q, parity_err_d;
  logic        frame_err_q, frame_err_d;

  logic        sample_pt, half_pt, fall_edge, exp_par, finish, stop_bad;

  assign sample_pt = (ctr_q == baud_divisor - 12'd1);
  assign half_pt   = (ctr_q == {1'b0, baud_divisor[11:1]} - 12'd1);
  assign fall_edge = rx_prev_q & ~rx_s2_q;
  assign exp_par   = parity_sel ? ~(^shift_q) : (^shift_q);

  // Handshake: rx_valid is a one-cycle strobe with no back-pressure; rx_data and
  // the error flags are valid in that cycle and hold until the next completed frame.
  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q + 12'd1;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    stop_err_d   = stop_err_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    finish       = 1'b0;
    stop_bad     = 1'b0;

    case (state_q)
      S_IDLE: begin
        ctr_d = 12'd0;
        if (fall_edge) state_d = S_START;
      end
      S_START: begin
        if (half_pt) begin
          ctr_d     = 12'd0;
          bit_cnt_d = 3'd0;
          state_d   = rx_s2_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (sample_pt) begin
          ctr_d     = 12'd0;
          shift_d   = {rx_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (sample_pt) begin
          ctr_d     = 12'd0;
          par_bit_d = rx_s2_q;
          state_d   = S_STOP1;
        end
      end
      S_STOP1: begin
        if (sample_pt) begin
          ctr_d      = 12'd0;
          stop_err_d = ~rx_s2_q;
          if (two_stop_bits) begin
            state_d = S_STOP2;
          end else begin
            finish   = 1'b1;
            stop_bad = ~rx_s2_q;
          end
        end
      end
      S_STOP2: begin
        if (sample_pt) begin
          ctr_d    = 12'd0;
          finish   = 1'b1;
          stop_bad = stop_err_q | ~rx_s2_q;
        end
      end
      S_DONE: begin
        ctr_d   = 12'd0;
        state_d = S_IDLE;
      end
      default: begin
        ctr_d   = 12'd0;
        state_d = S_IDLE;
      end
    endcase

    // Results are latched on the final stop sample so they line up with the
    // strobe, which is high for the single cycle spent in DONE.
    if (finish) begin
      state_d      = S_DONE;
      rx_data_d    = shift_q;
      parity_err_d = (par_bit_q != exp_par);
      frame_err_d  = stop_bad;
      rx_valid_d   = 1'b1;
    end

    if (!rx_sel) begin
      state_d      = S_IDLE;
      ctr_d        = 12'd0;
      bit_cnt_d    = 3'd0;
      shift_d      = 8'h00;
      rx_data_d    = rx_data_q;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      rx_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      ctr_q        <= 12'd0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_bit_q    <= 1'b0;
      stop_err_q   <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_s1_q      <= rx_in;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      ctr_q        <= ctr_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      stop_err_q   <= stop_err_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_rx_datapath.sv
// Directed bench for rx_datapath: table of single frames plus hand-written
// sequences for break, glitch, back-to-back, receiver disable and mid-frame reset.
module tb_rx_datapath;

  logic        clk;
  logic        reset;
  logic        rx_in;
  logic [11:0] baud_divisor;
  logic        parity_sel;
  logic        two_stop_bits;
  logic        rx_sel;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        parity_err;
  logic        frame_err;
  logic        rx_busy;

  rx_datapath dut (
    .clk           (clk),
    .reset         (reset),
    .rx_in         (rx_in),
    .baud_divisor  (baud_divisor),
    .parity_sel    (parity_sel),
    .two_stop_bits (two_stop_bits),
    .rx_sel        (rx_sel),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .parity_err    (parity_err),
    .frame_err     (frame_err),
    .rx_busy       (rx_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int valid_count = 0;
  int exp_valid_count = 0;
  logic       valid_prev = 1'b0;
  logic [9:0] last_exp = 10'h000;
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_count++;
      check("valid_width", {31'd0, valid_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {22'd0, rx_data, parity_err, frame_err}, 32'h3ff);
      end else begin
        last_exp = exp_q.pop_front();
        check("frame", {22'd0, rx_data, parity_err, frame_err}, {22'd0, last_exp});
      end
    end
    valid_prev = rx_valid;
  end

  // driver tasks (called at a falling edge)
  task automatic drive_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_in = bits[i];
      repeat (int'(baud_divisor)) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pinv, input logic s1, input logic s2);
    logic p;
    p = (parity_sel ? ~(^d) : (^d)) ^ pinv;
    drive_bits({4'b0, s2, s1, p, d, 1'b0}, two_stop_bits ? 12 : 11);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe);
    exp_q.push_back({d, pe, fe});
    exp_valid_count++;
  endtask

  task automatic idle_cycles(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [11:0] bd;
    logic        psel;
    logic        two;
    logic [7:0]  data;
    logic        pinv;
    logic        s1;
    logic        s2;
    logic [7:0]  exp_data;
    logic        exp_perr;
    logic        exp_ferr;
  } vec_t;

  vec_t vecs[8];
  logic saw_busy;

  initial begin
    vecs[0] = '{12'd16, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{12'd16, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{12'd16, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[3] = '{12'd16, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[4] = '{12'd16, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[5] = '{12'd16, 1'b1, 1'b0, 8'h12, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b1};
    vecs[6] = '{12'd7,  1'b1, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1, 8'h96, 1'b0, 1'b0};
    vecs[7] = '{12'd5,  1'b0, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0};

    reset = 1'b0;
    rx_in = 1'b1;
    rx_sel = 1'b1;
    baud_divisor = 12'd16;
    parity_sel = 1'b1;
    two_stop_bits = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_parity_err", {31'd0, parity_err}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    reset = 1'b1;
    idle_cycles(4);

    // single frames from the table
    for (int i = 0; i < 8; i++) begin
      baud_divisor  = vecs[i].bd;
      parity_sel    = vecs[i].psel;
      two_stop_bits = vecs[i].two;
      expect_frame(vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
      send_frame(vecs[i].data, vecs[i].pinv, vecs[i].s1, vecs[i].s2);
      idle_cycles(int'(vecs[i].bd) * 3 + 8);
      check("table_valid_count", valid_count, exp_valid_count);
      check("table_idle_busy", {31'd0, rx_busy}, 32'd0);
    end

    // second stop bit low, then line held low (break)
    baud_divisor = 12'd16;
    parity_sel = 1'b1;
    two_stop_bits = 1'b1;
    expect_frame(8'h3C, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    rx_in = 1'b0;
    repeat (100) @(negedge clk);
    check("break_valid_count", valid_count, exp_valid_count);
    check("break_busy", {31'd0, rx_busy}, 32'd0);
    idle_cycles(40);
    check("break_release_count", valid_count, exp_valid_count);

    // 3-cycle low glitch on the idle line
    two_stop_bits = 1'b0;
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      saw_busy = saw_busy | rx_busy;
      @(negedge clk);
    end
    check("glitch_busy_pulse", {31'd0, saw_busy}, 32'd1);
    check("glitch_busy_end", {31'd0, rx_busy}, 32'd0);
    check("glitch_valid_count", valid_count, exp_valid_count);
    check("glitch_outputs_held", {22'd0, rx_data, parity_err, frame_err}, {22'd0, last_exp});

    // back-to-back frames at the minimum divisor
    baud_divisor = 12'd4;
    expect_frame(8'h00, 1'b0, 1'b0);
    expect_frame(8'hFF, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
    idle_cycles(30);
    check("b2b_valid_count", valid_count, exp_valid_count);

    // receiver disabled in the middle of a frame
    baud_divisor = 12'd16;
    drive_bits({10'd0, 6'b101010}, 6);
    check("rxsel_busy_mid", {31'd0, rx_busy}, 32'd1);
    rx_sel = 1'b0;
    rx_in = 1'b1;
    @(negedge clk);
    check("rxsel_busy_off", {31'd0, rx_busy}, 32'd0);
    check("rxsel_outputs_held", {22'd0, rx_data, parity_err, frame_err}, {22'd0, last_exp});
    repeat (200) @(negedge clk);
    rx_sel = 1'b1;
    idle_cycles(10);
    check("rxsel_valid_count", valid_count, exp_valid_count);

    // reset pulse during the data bits of 0x55
    drive_bits({12'd0, 4'b1010}, 4);
    repeat (8) @(negedge clk);
    check("rst_mid_busy_before", {31'd0, rx_busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rx_in = 1'b1;
    check("rst_mid_rx_data", {24'd0, rx_data}, 32'h00);
    check("rst_mid_busy", {31'd0, rx_busy}, 32'd0);
    check("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
    idle_cycles(200);
    check("rst_mid_valid_count", valid_count, exp_valid_count);
    expect_frame(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b1, 1'b1);
    idle_cycles(60);
    check("post_reset_valid_count", valid_count, exp_valid_count);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
